// File: rtl/pid_duty_pipe.sv
// Three-stage pitch PID to motor duty pipeline: error saturation, integrator, derivative history.
// Optional SLEW_LIMIT_EN macro rate-limits duty changes in the signed-duty domain.
module pid_duty_pipe #(
  parameter int PTCH_W   = 16,
  parameter int ERR_W    = 10,
  parameter int D_DEPTH  = 2,
  parameter int D_SAT_W  = 7,
  parameter int D_COEFF  = 9,
  parameter int INTEG_W  = 18,
  parameter int I_SHIFT  = 7,
  parameter int DUTY_W   = 11,
  parameter int MIN_DUTY = 980
`ifdef SLEW_LIMIT_EN
  , parameter int SLEW_MAX = 64
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vld,
  input  logic signed [PTCH_W-1:0] ptch,
  input  logic                     pwr_up,
  input  logic                     rider_off,
  output logic                     duty_vld,
  output logic [DUTY_W-1:0]        mtr_duty,
  output logic                     rev
);

  localparam int DIFF_W = ERR_W + 1;
  localparam int D_W    = D_SAT_W + $clog2(D_COEFF + 1);
  localparam int I_W    = INTEG_W - I_SHIFT;
  localparam int M1_W   = (ERR_W > I_W) ? ERR_W : I_W;
  localparam int M_W    = (M1_W > D_W) ? M1_W : D_W;
  localparam int PID_W  = M_W + 2;
  localparam int SUM_W  = ((PID_W > DUTY_W) ? PID_W : DUTY_W) + 1;

  localparam logic signed [PTCH_W-1:0] P_MAX  = PTCH_W'((2 ** (ERR_W - 1)) - 1);
  localparam logic signed [PTCH_W-1:0] P_MIN  = PTCH_W'(-(2 ** (ERR_W - 1)));
  localparam logic signed [DIFF_W-1:0] DS_MAX = DIFF_W'((2 ** (D_SAT_W - 1)) - 1);
  localparam logic signed [DIFF_W-1:0] DS_MIN = DIFF_W'(-(2 ** (D_SAT_W - 1)));
  localparam logic signed [PID_W-1:0]  D_K    = PID_W'(D_COEFF);
  localparam logic [SUM_W-1:0]         DUTY_MAX = SUM_W'((2 ** DUTY_W) - 1);
  localparam logic [SUM_W-1:0]         MIN_V    = SUM_W'(MIN_DUTY);

  logic signed [ERR_W-1:0]   hist [D_DEPTH];
  logic signed [ERR_W-1:0]   err_sat, s1_err;
  logic signed [DIFF_W-1:0]  diff_raw;
  logic signed [D_SAT_W-1:0] ddiff_sat, s1_ddiff;
  logic signed [INTEG_W-1:0] integ, err_ext, integ_sum;
  logic                      integ_ovf, s1_vld;

  always_comb begin
    if (ptch > P_MAX)      err_sat = P_MAX[ERR_W-1:0];
    else if (ptch < P_MIN) err_sat = P_MIN[ERR_W-1:0];
    else                   err_sat = ptch[ERR_W-1:0];
    diff_raw = DIFF_W'(err_sat) - DIFF_W'(hist[D_DEPTH-1]);
    if (diff_raw > DS_MAX)      ddiff_sat = DS_MAX[D_SAT_W-1:0];
    else if (diff_raw < DS_MIN) ddiff_sat = DS_MIN[D_SAT_W-1:0];
    else                        ddiff_sat = diff_raw[D_SAT_W-1:0];
    err_ext   = INTEG_W'(err_sat);
    integ_sum = integ + err_ext;
    integ_ovf = (integ[INTEG_W-1] == err_ext[INTEG_W-1]) &&
                (integ_sum[INTEG_W-1] != integ[INTEG_W-1]);
  end

  // Clears are written last so they win over the accumulate/shift of the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_err   <= '0;
      s1_ddiff <= '0;
      integ    <= '0;
      for (int i = 0; i < D_DEPTH; i++) hist[i] <= '0;
    end else begin
      s1_vld <= vld;
      if (vld) begin
        s1_err   <= err_sat;
        s1_ddiff <= ddiff_sat;
        for (int i = D_DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= err_sat;
        if (!integ_ovf) integ <= integ_sum;
      end
      if (!pwr_up)
        for (int i = 0; i < D_DEPTH; i++) hist[i] <= '0;
      if (rider_off || !pwr_up) integ <= '0;
    end
  end

  logic signed [PID_W-1:0] p_term, i_term, d_term, pid_sum, pid;
  logic                    s2_vld;

  always_comb begin
    p_term  = PID_W'(s1_err >>> 1) + PID_W'(s1_err >>> 2);
    i_term  = PID_W'(integ >>> I_SHIFT);
    d_term  = PID_W'(s1_ddiff) * D_K;
    pid_sum = p_term + i_term + d_term;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
      pid    <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) pid <= pid_sum;
    end
  end

  logic [PID_W-1:0]  pid_abs;
  logic [SUM_W-1:0]  duty_sum;
  logic [DUTY_W-1:0] tgt_duty, nxt_duty;
  logic              tgt_rev, nxt_rev;

  always_comb begin
    tgt_rev  = pid[PID_W-1];
    pid_abs  = tgt_rev ? $unsigned(-pid) : $unsigned(pid);
    duty_sum = MIN_V + SUM_W'(pid_abs);
    tgt_duty = (duty_sum > DUTY_MAX) ? DUTY_MAX[DUTY_W-1:0] : duty_sum[DUTY_W-1:0];
  end

`ifdef SLEW_LIMIT_EN
  localparam logic [SUM_W-1:0] SLEW = SUM_W'(SLEW_MAX);
  logic [SUM_W-1:0] cur, tgt;

  // Opposite sign: shrink toward MIN_DUTY, flip rev only once there.
  always_comb begin
    cur = SUM_W'(mtr_duty);
    tgt = SUM_W'(tgt_duty);
    if ((rev == tgt_rev) || (mtr_duty == '0)) begin
      nxt_rev = tgt_rev;
      if (tgt > cur + SLEW)      nxt_duty = DUTY_W'(cur + SLEW);
      else if (cur > tgt + SLEW) nxt_duty = DUTY_W'(cur - SLEW);
      else                       nxt_duty = tgt_duty;
    end else if (cur > MIN_V + SLEW) begin
      nxt_rev  = rev;
      nxt_duty = DUTY_W'(cur - SLEW);
    end else begin
      nxt_rev  = tgt_rev;
      nxt_duty = DUTY_W'(MIN_V);
    end
  end
`else
  always_comb begin
    nxt_duty = tgt_duty;
    nxt_rev  = tgt_rev;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_vld <= 1'b0;
      mtr_duty <= '0;
      rev      <= 1'b0;
    end else begin
      duty_vld <= s2_vld;
      if (s2_vld) begin
        if (!pwr_up) begin
          mtr_duty <= '0;
          rev      <= 1'b0;
        end else begin
          mtr_duty <= nxt_duty;
          rev      <= nxt_rev;
        end
      end
    end
  end

endmodule
